wand_arbiter: RTL

- Parametrised wired-AND bus arbiter for N_CH requesters.
- Each requester presents an ID_W-bit priority ID. IDs are resolved bit-serially, MSB first, on a modelled wired-AND line: 0 is dominant, 1 is recessive, so the lowest ID wins (CAN/I2C style).
- Sits between multiple agents and a single shared resource. Reports bus-line activity, surviving contenders, the winner, and equal-ID ties.

---
 rtl/wand_arbiter_if.sv | 26 ++
 rtl/wand_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/wand_arbiter_if.sv
// Bus bundle between the requesting agents (master) and the wired-AND arbiter (slave).
// Carries the request/ID inputs and every arbitration status output.
interface wand_arbiter_if #(
  parameter int N_CH = 4,
  parameter int ID_W = 8
);
  logic [N_CH-1:0]      req;
  logic [N_CH*ID_W-1:0] id;
  logic                 bus_bit;
  logic [N_CH-1:0]      active;
  logic [N_CH-1:0]      grant;
  logic [ID_W-1:0]      grant_id;
  logic                 busy;
  logic                 done;
  logic                 tie;

  modport master (
    output req, id,
    input  bus_bit, active, grant, grant_id, busy, done, tie
  );

  modport slave (
    input  req, id,
    output bus_bit, active, grant, grant_id, busy, done, tie
  );
endinterface

// File: rtl/wand_arbiter.sv
// Bit-serial wired-AND arbiter: IDs are resolved MSB first, a 0 dominates,
// so the lowest snapshotted ID wins and holds the grant while it keeps requesting.
module wand_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  wand_arbiter_if.slave bus
);

  localparam int IDX_W = (ID_W > 1) ? $clog2(ID_W) : 1;
  localparam int CH_W  = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [N_CH-1:0]  active_q, active_d;
  logic [N_CH-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  idreg_q [N_CH];
  logic [ID_W-1:0]  idreg_d [N_CH];
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic             bus_bit_q, bus_bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tie_q, tie_d;

  logic             resolved;
  logic [N_CH-1:0]  survivors;
  logic [CH_W-1:0]  winner;
  logic [CH_W:0]    popcnt;

  // Resolve the current bit on the modelled line; recessive contenders that see a
  // dominant 0 drop out. The winner/tie terms only matter once the mask is final.
  always_comb begin
    resolved  = 1'b1;
    survivors = active_q;
    winner    = '0;
    popcnt    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (active_q[k] && !idreg_q[k][bit_idx_q]) resolved = 1'b0;
    end
    for (int k = 0; k < N_CH; k++) begin
      if (active_q[k] && idreg_q[k][bit_idx_q] && !resolved) survivors[k] = 1'b0;
      popcnt = popcnt + (CH_W+1)'(active_q[k]);
    end
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (active_q[k]) winner = CH_W'(k);
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    active_d   = active_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    bus_bit_d  = bus_bit_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    tie_d      = tie_q;
    idreg_d    = idreg_q;
    case (state_q)
      IDLE: begin
        bus_bit_d = 1'b1;
        if (|bus.req) begin
          active_d = bus.req;
          for (int k = 0; k < N_CH; k++) idreg_d[k] = bus.id[k*ID_W +: ID_W];
          bit_idx_d = IDX_W'(ID_W - 1);
          busy_d    = 1'b1;
          state_d   = ARB;
        end
      end
      ARB: begin
        bus_bit_d = resolved;
        active_d  = survivors;
        if (bit_idx_q == '0) state_d = GRANT;
        else                 bit_idx_d = bit_idx_q - 1'b1;
      end
      GRANT: begin
        // The first GRANT cycle publishes the result; afterwards the grant holds
        // until the winner lets go of its request.
        if (grant_q == '0) begin
          grant_d    = {{(N_CH-1){1'b0}}, 1'b1} << winner;
          grant_id_d = idreg_q[winner];
          tie_d      = (popcnt > 1);
          done_d     = 1'b1;
        end else if (!bus.req[winner]) begin
          grant_d   = '0;
          active_d  = '0;
          tie_d     = 1'b0;
          busy_d    = 1'b0;
          bus_bit_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_idx_q  <= IDX_W'(ID_W - 1);
      active_q   <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      bus_bit_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tie_q      <= 1'b0;
      for (int k = 0; k < N_CH; k++) idreg_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      active_q   <= active_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      bus_bit_q  <= bus_bit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tie_q      <= tie_d;
      idreg_q    <= idreg_d;
    end
  end

  assign bus.bus_bit  = bus_bit_q;
  assign bus.active   = active_q;
  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tie      = tie_q;

endmodule
